// File: rtl/zf_h2s_sched.sv
// zf_h2s_sched
//   Descriptor scheduler for the ZYNQ FIFO host-to-stream read engine.
//   Two per-channel queues of host buffer addresses are filled over the
//   settings bus. A round-robin arbiter hands one address at a time to the
//   engine's mem_addr/mem_valid/mem_ack port. Each completed buffer is
//   reported with a per-channel strobe, a wrapping count and the queue level.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   set_stb, set_addr, set_data    settings bus write
//                                  (SR_BASE+0/+1 push, SR_BASE+2 control)
//   mem_addr, mem_valid, mem_ack   engine configuration handshake
//   done_stb[1:0]                  one-cycle completion pulse per channel
//   ch0/ch1_done_count             completed buffers per channel (wraps)
//   ch0/ch1_level                  queued entries including the in-flight one
//   overflow[1:0]                  sticky, push dropped on a full queue
//   debug                          state and status bits
module zf_h2s_sched #(
    parameter int SR_BASE    = 0,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_stb,
    input  logic [7:0]            set_addr,
    input  logic [31:0]           set_data,
    output logic [31:0]           mem_addr,
    output logic                  mem_valid,
    input  logic                  mem_ack,
    output logic [1:0]            done_stb,
    output logic [15:0]           ch0_done_count,
    output logic [15:0]           ch1_done_count,
    output logic [DEPTH_LOG2:0]   ch0_level,
    output logic [DEPTH_LOG2:0]   ch1_level,
    output logic [1:0]            overflow,
    output logic [31:0]           debug
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [7:0]          ADDR_Q0  = 8'(SR_BASE);
    localparam logic [7:0]          ADDR_Q1  = 8'(SR_BASE + 1);
    localparam logic [7:0]          ADDR_CTL = 8'(SR_BASE + 2);

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } state_t;

    state_t                 state, state_nx;

    logic [31:0]            q_mem  [2][DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr [2];
    logic [DEPTH_LOG2-1:0]  rd_ptr [2];
    logic [DEPTH_LOG2:0]    level  [2];
    logic [15:0]            done_cnt [2];
    logic [31:0]            head   [2];

    logic [1:0]             chan_en;
    logic [1:0]             ovf;
    logic                   grant;
    logic                   last_grant;
    logic                   aborted;

    logic                   ctl_wr;
    logic                   clr;
    logic [1:0]             push_req;
    logic [1:0]             push_ok;
    logic [1:0]             elig;
    logic [1:0]             pop;
    logic                   start;
    logic                   complete;
    logic                   grant_sel;

    // Settings decode, queue status and arbitration.
    always_comb begin
        ctl_wr      = set_stb && (set_addr == ADDR_CTL);
        clr         = ctl_wr && set_data[2];
        push_req[0] = set_stb && (set_addr == ADDR_Q0);
        push_req[1] = set_stb && (set_addr == ADDR_Q1);
        for (int unsigned c = 0; c < 2; c++) begin
            // Fullness is judged on the pre-edge level, so a same-cycle pop
            // does not make room for a push.
            push_ok[c] = push_req[c] && (level[c] != LVL_FULL);
            // Only evaluated in IDLE, where nothing is in flight.
            elig[c]    = chan_en[c] && (level[c] != '0);
            head[c]    = q_mem[c][rd_ptr[c]];
        end
        grant_sel = (&elig) ? ~last_grant : elig[1];
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        complete = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|elig) begin
                    start    = 1'b1;
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_ack) begin
                    state_nx = ST_IDLE;
                    // A clear (earlier or on this very cycle) turns the ack
                    // into a no-op: the entry it referred to is gone.
                    complete = ~aborted & ~clr;
                end
            end
        endcase
        pop = complete ? (grant ? 2'b10 : 2'b01) : 2'b00;
    end

    // Control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            aborted    <= 1'b0;
            mem_addr   <= '0;
            chan_en    <= '0;
            done_stb   <= '0;
        end else begin
            state    <= state_nx;
            done_stb <= pop;
            if (start) begin
                grant    <= grant_sel;
                mem_addr <= head[grant_sel];
            end
            if (state == ST_ISSUE && mem_ack) begin
                last_grant <= grant;
            end
            // Covers a clear landing in ISSUE and a clear on the same edge
            // as a new grant.
            if (state_nx == ST_IDLE) begin
                aborted <= 1'b0;
            end else if (clr) begin
                aborted <= 1'b1;
            end
            if (ctl_wr) begin
                chan_en <= set_data[1:0];
            end
        end
    end

    // Queue pointers, levels, counts and overflow flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < 2; c++) begin
                wr_ptr[c]   <= '0;
                rd_ptr[c]   <= '0;
                level[c]    <= '0;
                done_cnt[c] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int unsigned c = 0; c < 2; c++) begin
                if (clr) begin
                    wr_ptr[c]   <= '0;
                    rd_ptr[c]   <= '0;
                    level[c]    <= '0;
                    done_cnt[c] <= '0;
                    ovf[c]      <= 1'b0;
                end else begin
                    if (push_ok[c]) begin
                        wr_ptr[c] <= wr_ptr[c] + 1'b1;
                    end
                    if (pop[c]) begin
                        rd_ptr[c]   <= rd_ptr[c] + 1'b1;
                        done_cnt[c] <= done_cnt[c] + 1'b1;
                    end
                    if (push_req[c] && !push_ok[c]) begin
                        ovf[c] <= 1'b1;
                    end
                    if (push_ok[c] && !pop[c]) begin
                        level[c] <= level[c] + 1'b1;
                    end else if (!push_ok[c] && pop[c]) begin
                        level[c] <= level[c] - 1'b1;
                    end
                end
            end
        end
    end

    // Queue storage; no reset needed, contents are qualified by the levels.
    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < 2; c++) begin
            if (push_ok[c]) begin
                q_mem[c][wr_ptr[c]] <= {set_data[31:3], 3'b000};
            end
        end
    end

    assign mem_valid      = (state == ST_ISSUE);
    assign ch0_done_count = done_cnt[0];
    assign ch1_done_count = done_cnt[1];
    assign ch0_level      = level[0];
    assign ch1_level      = level[1];
    assign overflow       = ovf;
    assign debug          = {22'd0, elig, ovf, chan_en, last_grant, grant,
                             aborted, mem_valid};

endmodule
